// File: rtl/parallel_pkg.sv
// Shared definitions for the parallel-bus receive framer: byte width,
// default start-of-frame marker and the framer state encoding.
package parallel_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

endpackage

// File: rtl/bus_sync.sv
// Brings the Pi's asynchronous strobe, chip select and data pins into the
// clock domain and turns each strobe falling edge (while selected) into a
// single-cycle byte strobe carrying the sampled data.
module bus_sync
  import parallel_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bus_clock,
  input  logic              chip_select,
  input  logic [BYTE_W-1:0] bus_data,
  output logic              cap,
  output logic [BYTE_W-1:0] cap_data,
  output logic              cs_sync
);

  logic              bclk_s1, bclk_s2, bclk_d;
  logic              cs_s1, cs_s2;
  logic [BYTE_W-1:0] data_s1, data_s2;

  // Two-flop synchronizers for every pin, plus a delayed strobe copy for edge detection.
  // NOTE: non-blocking assignments make each stage take the previous stage's old value;
  // blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_d  <= 1'b0;
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      bclk_s1 <= bus_clock;
      bclk_s2 <= bclk_s1;
      bclk_d  <= bclk_s2;
      cs_s1   <= chip_select;
      cs_s2   <= cs_s1;
      data_s1 <= bus_data;
      data_s2 <= data_s1;
    end
  end

  // Registered falling-edge detect: one cap pulse per strobe while the FPGA is reading.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap      <= 1'b0;
      cap_data <= '0;
    end else begin
      cap      <= bclk_d & ~bclk_s2 & cs_s2;
      cap_data <= data_s2;
    end
  end

  assign cs_sync = cs_s2;

endmodule

// File: rtl/parallel_frame_rx.sv
// Receive framer: parses SOF / LEN / payload / checksum frames from the
// synchronized bus, buffers the payload and releases it on a ready/valid
// stream only after the checksum verifies.
module parallel_frame_rx
  import parallel_pkg::*;
#(
  parameter int                MAX_LEN = 16,
  parameter logic [BYTE_W-1:0] SOF     = SOF_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bus_clock,
  input  logic              chip_select,
  input  logic [BYTE_W-1:0] bus_data,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              frame_ok,
  output logic              frame_err,
  output logic              rx_overrun
);

  // Address width of the payload buffer; the counters carry one extra bit so
  // they can hold the value MAX_LEN itself.
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int IW = AW + 1;

  localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);
  localparam logic [IW-1:0]     IDX_ONE   = IW'(1);

  logic              cap;
  logic [BYTE_W-1:0] cap_data;
  logic              cs_sync;
  logic              cs_prev;
  logic              cs_fall;

  state_t            state;
  logic [IW-1:0]     len_q;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     rd;
  logic [BYTE_W-1:0] sum;

  logic [BYTE_W-1:0] mem [MAX_LEN];

  logic [IW-1:0]     idx_next;
  logic [IW-1:0]     rd_next;
  logic              handshake;
  logic              mem_wr;

  bus_sync u_bus_sync (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus_clock   (bus_clock),
    .chip_select (chip_select),
    .bus_data    (bus_data),
    .cap         (cap),
    .cap_data    (cap_data),
    .cs_sync     (cs_sync)
  );

  assign cs_fall   = cs_prev & ~cs_sync;
  assign idx_next  = idx + IDX_ONE;
  assign rd_next   = rd + IDX_ONE;
  assign handshake = out_valid & out_ready;
  assign mem_wr    = (state == ST_PAYLOAD) && cap && !cs_fall;

  // Payload buffer write port.
  // NOTE: the buffer has no reset; every location is written before it is read,
  // and a reset would stop it mapping onto a plain register file or RAM.
  always_ff @(posedge clock) begin
    if (mem_wr) begin
      mem[idx[AW-1:0]] <= cap_data;
    end
  end

  // Frame parser, checksum accumulator and registered output stream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      idx        <= '0;
      rd         <= '0;
      sum        <= '0;
      cs_prev    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      cs_prev    <= cs_sync;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cap && cap_data == SOF) begin
            state <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (cs_fall) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (cap) begin
            if (cap_data == '0 || cap_data > MAX_LEN_B) begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              len_q <= IW'(cap_data);
              sum   <= cap_data;
              idx   <= '0;
              state <= ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (cs_fall) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (cap) begin
            sum <= sum + cap_data;
            idx <= idx_next;
            if (idx_next == len_q) begin
              state <= ST_CHK;
            end
          end
        end

        ST_CHK: begin
          if (cs_fall) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (cap) begin
            if (cap_data == sum) begin
              frame_ok  <= 1'b1;
              out_valid <= 1'b1;
              out_data  <= mem[0];
              out_last  <= (len_q == IDX_ONE);
              rd        <= '0;
              state     <= ST_DRAIN;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end

        ST_DRAIN: begin
          // The bus cannot be back-pressured, so bytes arriving now are lost.
          if (cap) begin
            rx_overrun <= 1'b1;
          end
          if (handshake) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              rd       <= rd_next;
              out_data <= mem[rd_next[AW-1:0]];
              out_last <= (rd_next == len_q - IDX_ONE);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_frame_rx.sv
// Self-checking bench for parallel_frame_rx: a table of directed frames,
// hand-written multi-cycle corner cases, and random frames checked against
// a frame-level reference model.
module tb_parallel_frame_rx;

  localparam int MAX_LEN = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       bus_clock;
  logic       chip_select;
  logic [7:0] bus_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       frame_ok;
  logic       frame_err;
  logic       rx_overrun;

  always #5 clock = ~clock;

  parallel_frame_rx #(.MAX_LEN(MAX_LEN), .SOF(8'hA5)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus_clock   (bus_clock),
    .chip_select (chip_select),
    .bus_data    (bus_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .rx_overrun  (rx_overrun)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  int         cyc = 0;
  int         ok_cnt, err_cnt, ovr_cnt;
  int         excl_bad = 0, hold_bad = 0, okv_bad = 0;
  logic [8:0] rx_q[$];
  int         hs_cyc[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (out_valid && out_ready) begin
        rx_q.push_back({out_last, out_data});
        hs_cyc.push_back(cyc);
      end
      if (frame_ok)   ok_cnt++;
      if (frame_err)  err_cnt++;
      if (rx_overrun) ovr_cnt++;
      if ((int'(frame_ok) + int'(frame_err) + int'(rx_overrun)) > 1) excl_bad++;
      if (frame_ok && !out_valid) okv_bad++;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
        hold_bad++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] tx_q[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_data  = b;
    bus_clock = 1'b1;
    tick(4);
    bus_clock = 1'b0;
    tick(4);
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i]);
    tx_q.delete();
  endtask

  task automatic clear_mon();
    rx_q.delete();
    hs_cyc.delete();
    ok_cnt  = 0;
    err_cnt = 0;
    ovr_cnt = 0;
  endtask

  // Waits (bounded) for the output stream to go idle; optionally jitters out_ready.
  task automatic wait_drain(input bit rnd);
    int n = 0;
    tick(4);
    while (out_valid === 1'b1 && n < 400) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      tick(1);
      n++;
    end
    out_ready = 1'b1;
    tick(2);
    check("drain_done", {31'd0, out_valid}, 32'd0);
  endtask

  function automatic logic [31:0] outs_now();
    return {19'd0, out_data, out_valid, out_last, frame_ok, frame_err, rx_overrun};
  endfunction

  // ---------------- directed vector table ----------------
  // Frame bytes and expected payload are left-aligned: first byte in [63:56].
  typedef struct {
    string       name;
    int          n;
    logic [63:0] in_b;
    int          ok;
    int          err;
    int          nout;
    logic [63:0] out_b;
  } vec_t;

  vec_t vecs[6];

  // ---------------- random-frame reference model ----------------
  task automatic random_frames(input int count);
    logic [7:0] exp_q[$];
    logic [7:0] pay[$];
    int         exp_ok, exp_err, kind, len, junk;
    logic [7:0] b, csum, chk;
    for (int it = 0; it < count; it++) begin
      clear_mon();
      exp_q.delete();
      pay.delete();
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        tx_q.push_back(b);
      end
      kind    = (it == 0) ? 0 : $urandom_range(0, 3);
      exp_ok  = 0;
      exp_err = 0;
      tx_q.push_back(8'hA5);
      if (kind == 3) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        tx_q.push_back(8'(len));
        exp_err = 1;
      end else begin
        len = (it == 0) ? MAX_LEN : $urandom_range(1, MAX_LEN);
        tx_q.push_back(8'(len));
        for (int k = 0; k < len; k++) pay.push_back(8'($urandom_range(0, 255)));
        csum = 8'(len);
        foreach (pay[k]) csum = csum + pay[k];
        if (kind == 2) begin
          chk     = csum + 8'($urandom_range(1, 255));
          exp_err = 1;
        end else begin
          chk    = csum;
          exp_ok = 1;
          exp_q  = pay;
        end
        foreach (pay[k]) tx_q.push_back(pay[k]);
        tx_q.push_back(chk);
      end
      out_ready = 1'b1;
      send_q();
      wait_drain(1'b1);
      check($sformatf("rnd%0d_ok", it), ok_cnt, exp_ok);
      check($sformatf("rnd%0d_err", it), err_cnt, exp_err);
      check($sformatf("rnd%0d_nbytes", it), rx_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
        check($sformatf("rnd%0d_byte%0d", it, k), {23'd0, rx_q[k]},
              {23'd0, (k == exp_q.size() - 1), exp_q[k]});
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{"frameA",      6, 64'hA503_1122_3369_0000, 1, 0, 3, 64'h1122_3300_0000_0000};
    vecs[1] = '{"bad_chk",     6, 64'hA503_1122_3368_0000, 0, 1, 0, 64'h0};
    vecs[2] = '{"junk_then",   6, 64'h5A00_A501_7F80_0000, 1, 0, 1, 64'h7F00_0000_0000_0000};
    vecs[3] = '{"len_zero",    4, 64'hA500_0102_0000_0000, 0, 1, 0, 64'h0};
    vecs[4] = '{"len_big",     4, 64'hA511_2233_0000_0000, 0, 1, 0, 64'h0};
    vecs[5] = '{"sof_in_pay",  4, 64'hA501_A5A6_0000_0000, 1, 0, 1, 64'hA500_0000_0000_0000};

    reset_n     = 1'b0;
    bus_clock   = 1'b0;
    chip_select = 1'b1;
    bus_data    = 8'h00;
    out_ready   = 1'b1;
    clear_mon();
    tick(3);
    check("reset_outputs", outs_now(), 32'd0);
    reset_n = 1'b1;
    tick(3);

    // Table-driven directed frames.
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      for (int i = 0; i < vecs[v].n; i++) tx_q.push_back(vecs[v].in_b[63-8*i -: 8]);
      send_q();
      wait_drain(1'b0);
      check({vecs[v].name, "_ok"}, ok_cnt, vecs[v].ok);
      check({vecs[v].name, "_err"}, err_cnt, vecs[v].err);
      check({vecs[v].name, "_ovr"}, ovr_cnt, 0);
      check({vecs[v].name, "_nbytes"}, rx_q.size(), vecs[v].nout);
      for (int k = 0; k < vecs[v].nout && k < rx_q.size(); k++)
        check($sformatf("%s_byte%0d", vecs[v].name, k), {23'd0, rx_q[k]},
              {23'd0, (k == vecs[v].nout - 1), vecs[v].out_b[63-8*k -: 8]});
      if (v == 0) begin
        check("frameA_hs_count", hs_cyc.size(), 3);
        if (hs_cyc.size() >= 3) begin
          check("frameA_back2back_1", hs_cyc[1] - hs_cyc[0], 1);
          check("frameA_back2back_2", hs_cyc[2] - hs_cyc[1], 1);
        end
      end
    end

    // Back-pressure with bytes arriving during drain.
    clear_mon();
    out_ready = 1'b0;
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_q();
    send_byte(8'hA5);
    send_byte(8'h01);
    tick(3);
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    check("stall_data", {24'd0, out_data}, 32'h11);
    check("stall_overrun", ovr_cnt, 2);
    check("stall_no_hs", rx_q.size(), 0);
    out_ready = 1'b1;
    wait_drain(1'b0);
    check("stall_ok", ok_cnt, 1);
    check("stall_err", err_cnt, 0);
    check("stall_nbytes", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("stall_b0", {23'd0, rx_q[0]}, {23'd0, 9'h011});
      check("stall_b1", {23'd0, rx_q[1]}, {23'd0, 9'h022});
      check("stall_b2", {23'd0, rx_q[2]}, {23'd0, 9'h133});
    end

    // chip_select abort mid-payload, then a clean one-byte frame.
    clear_mon();
    tx_q = '{8'hA5, 8'h02, 8'h11};
    send_q();
    chip_select = 1'b0;
    tick(10);
    chip_select = 1'b1;
    tick(4);
    tx_q = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    send_q();
    wait_drain(1'b0);
    check("cs_abort_err", err_cnt, 1);
    check("cs_abort_ok", ok_cnt, 1);
    check("cs_abort_nbytes", rx_q.size(), 1);
    if (rx_q.size() == 1) check("cs_abort_byte", {23'd0, rx_q[0]}, {23'd0, 9'h17F});

    // Reset mid-payload.
    tx_q = '{8'hA5, 8'h03, 8'h11};
    send_q();
    reset_n = 1'b0;
    tick(1);
    check("rst_payload_outs", outs_now(), 32'd0);
    reset_n = 1'b1;
    tick(2);
    clear_mon();
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_q();
    wait_drain(1'b0);
    check("rst_payload_ok", ok_cnt, 1);
    check("rst_payload_err", err_cnt, 0);
    check("rst_payload_nbytes", rx_q.size(), 3);
    if (rx_q.size() == 3) check("rst_payload_last", {23'd0, rx_q[2]}, {23'd0, 9'h133});

    // Reset mid-drain.
    out_ready = 1'b0;
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_q();
    tick(2);
    check("rst_drain_pre_valid", {31'd0, out_valid}, 32'd1);
    reset_n = 1'b0;
    tick(1);
    check("rst_drain_outs", outs_now(), 32'd0);
    out_ready = 1'b1;
    reset_n   = 1'b1;
    tick(2);
    check("rst_drain_after", outs_now(), 32'd0);
    clear_mon();
    tx_q = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    send_q();
    wait_drain(1'b0);
    check("rst_drain_ok", ok_cnt, 1);
    check("rst_drain_nbytes", rx_q.size(), 1);
    if (rx_q.size() == 1) check("rst_drain_byte", {23'd0, rx_q[0]}, {23'd0, 9'h17F});

    // Random frames against the frame-level model.
    random_frames(25);

    check("pulse_exclusive", excl_bad, 0);
    check("stall_hold", hold_bad, 0);
    check("ok_with_valid", okv_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/parallel_frame_rx.md
# parallel_frame_rx

Receive-side framing stage directly downstream of the 8-bit parallel bus transceiver. It samples the Raspberry Pi's asynchronous bus strobe, chip select and data pins into the FPGA clock domain and captures one byte per strobe falling edge while the FPGA is the reader. It parses the bytes into length-prefixed, checksummed frames and stores each payload. It releases a payload on a ready/valid byte stream only after its checksum verifies, so downstream logic never sees a corrupt frame.

## Interface
Parameters:
- MAX_LEN, 16: largest legal payload length in bytes (1..255); sets buffer depth.
- SOF, 8'hA5: start-of-frame byte.

Ports:
- clock  input  1  FPGA system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- bus_clock  input  1  Pi strobe, asynchronous to clock; byte valid on its falling edge.
- chip_select  input  1  asynchronous; high = FPGA reading the bus (transceiver convention).
- bus_data  input  8  pin data as seen by the transceiver, asynchronous.
- out_data  output  8  payload byte.
- out_valid  output  1  out_data valid.
- out_last  output  1  marks final payload byte of the frame; qualified by out_valid.
- out_ready  input  1  downstream accepts on out_valid & out_ready.
- frame_ok  output  1  one-cycle pulse: frame verified, drain starting.
- frame_err  output  1  one-cycle pulse: frame discarded (bad length, bad checksum, chip_select abort).
- rx_overrun  output  1  one-cycle pulse: byte captured during DRAIN and dropped.

## Operation
- bus_clock, chip_select and bus_data (all 8 bits) each pass through two flops. A falling edge of synchronized bus_clock with synchronized chip_select high yields a byte strobe `cap` carrying the synchronized data.
- States: IDLE, LEN, PAYLOAD, CHK, DRAIN.
- IDLE: on cap with byte == SOF -> LEN. Other bytes are ignored silently.
- LEN: on cap, store len. If len == 0 or len > MAX_LEN: frame_err, -> IDLE. Otherwise sum = len, idx = 0, -> PAYLOAD.
- PAYLOAD: on cap, write buf[idx], sum += byte (mod 256), idx++. -> CHK once idx reaches len.
- CHK: on cap, a byte equal to sum gives frame_ok and -> DRAIN with rd = 0. A mismatched byte gives frame_err and -> IDLE.
- DRAIN: present buf[rd]. On handshake, rd++. out_last = (rd == len-1). On the handshake of the last byte -> IDLE.
- Any cap in DRAIN is dropped, pulses rx_overrun, and does not change state. An SOF arriving in DRAIN is also lost.
- Synchronized chip_select falling while in LEN, PAYLOAD or CHK: frame_err, -> IDLE. chip_select falling in DRAIN has no effect, and drain completes.
- Checksum is the 8-bit modular sum of LEN and all payload bytes.

## Timing
- Reset values: out_data 0, out_valid 0, out_last 0, frame_ok 0, frame_err 0, rx_overrun 0. State is IDLE, all counters and synchronizers are 0, and buffer contents are don't-care.
- Pin to cap: 3 clocks after the pin edge (2 sync + 1 edge detect).
- The Pi must hold bus_data stable from 3 clocks before to 3 clocks after each bus_clock falling edge. Strobe high and low times must each be ≥ 3 clocks. Violations are out of scope.
- cap of the CHK byte -> frame_ok high the next cycle. out_valid is also high that cycle, with out_data = buf[0].
- out_data and out_last are registered and stable while out_valid & !out_ready. They advance one byte per handshake cycle, so full throughput is one byte per clock.
- out_valid drops the cycle after the last handshake. A new SOF is accepted from that same cycle onward.
- frame_ok, frame_err and rx_overrun are mutually exclusive in any cycle.
- A reset_n assertion mid-frame or mid-drain clears everything immediately. There are no partial outputs after release.

## Structure
- Shared package parallel_pkg: the SOF default constant, the state enum (IDLE/LEN/PAYLOAD/CHK/DRAIN), and the byte width constant 8.
- Sub-module bus_sync: the two-flop synchronizers for strobe, select and data plus the falling-edge detector. It outputs cap, cap_data and cs_sync.
- The buffer is an MAX_LEN×8 register array with an ⌈log2 MAX_LEN⌉+1 bit index inside parallel_frame_rx.

## Test plan
- Frame A5 03 11 22 33 69, out_ready held 1 -> frame_ok once; out_data 11, 22, 33 on consecutive cycles; out_last with 33; no error pulses.
- Same frame with checksum byte 68 -> frame_err once, out_valid never asserts, next valid frame is received correctly.
- Frame A5 00 and frame A5 11 (MAX_LEN = 16) -> frame_err on the LEN byte each time; trailing bytes are ignored until the next A5.
- Valid 3-byte frame with out_ready low for 10 cycles, then two bytes strobed in that window -> out_data holds 11 throughout, rx_overrun pulses twice, the drain then completes all 3 bytes.
- chip_select dropped after A5 02 11 -> frame_err; following A5 01 7F 80 -> frame_ok, output 7F with out_last.
- reset_n pulsed low mid-PAYLOAD and mid-DRAIN -> all outputs 0 next edge; a subsequent valid frame is received intact.
